// File: rtl/lock_code_store.sv
// Keypad code storage and comparison engine for the combination lock.
// Optional idle auto-clear of a partial entry is enabled with `define LOCK_ENTRY_TIMEOUT_EN.
module lock_code_store #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = 16'h1234,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              clear,
    input  logic                              enter,
    input  logic                              change,
    input  logic                              enable,
    output logic                              Compare,
    output logic                              entry_full,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_count
);

    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_DIGITS);

    logic [CODE_W-1:0] entry_buf;
    logic [CODE_W-1:0] stored_code;
    logic [CODE_W-1:0] next_entry_buf;
    logic [CODE_W-1:0] stored_code_next;
    logic [CNT_W-1:0]  next_count;
    logic              next_full;
    logic              clear_all;
    logic              accept;
    logic              load;
    logic              timeout_hit;

    // Load looks at the pre-clear buffer, so a change+enable edge commits the entry before it is wiped.
    always_comb begin
        clear_all        = clear || enter || change || timeout_hit;
        load             = enable && entry_full;
        accept           = digit_valid && !clear_all && (entry_count != FULL_COUNT);
        stored_code_next = load ? entry_buf : stored_code;
        next_entry_buf   = entry_buf;
        next_count       = entry_count;
        if (clear_all) begin
            next_entry_buf = '0;
            next_count     = '0;
        end else if (accept) begin
            next_entry_buf = {entry_buf[CODE_W-DIGIT_W-1:0], digit_in};
            next_count     = entry_count + CNT_W'(1);
        end
        next_full = (next_count == FULL_COUNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entry_buf   <= '0;
            stored_code <= DEFAULT_CODE;
            entry_count <= '0;
            entry_full  <= 1'b0;
            Compare     <= 1'b0;
        end else begin
            entry_buf   <= next_entry_buf;
            stored_code <= stored_code_next;
            entry_count <= next_count;
            entry_full  <= next_full;
            Compare     <= next_full && (next_entry_buf == stored_code_next);
        end
    end

`ifdef LOCK_ENTRY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_running;

    assign idle_running = (entry_count != '0) && (entry_count != FULL_COUNT);
    assign timeout_hit  = idle_running && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Idle time is only measured for a partial entry; any digit or clear restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (accept || clear_all || !idle_running) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_lock_code_store.sv
// Table-driven self-checking bench for lock_code_store; the stored code is observed through Compare.
module tb_lock_code_store;

    logic       clock;
    logic       reset;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       clear;
    logic       enter;
    logic       change;
    logic       enable;
    logic       Compare;
    logic       entry_full;
    logic [2:0] entry_count;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [3:0] d;
        logic       clr;
        logic       ent;
        logic       chg;
        logic       en;
        logic [2:0] cnt;
        logic       full;
        logic       cmp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    lock_code_store #(
        .DIGIT_W(4),
        .NUM_DIGITS(4),
        .DEFAULT_CODE(16'h1234),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .digit_in(digit_in),
        .digit_valid(digit_valid),
        .clear(clear),
        .enter(enter),
        .change(change),
        .enable(enable),
        .Compare(Compare),
        .entry_full(entry_full),
        .entry_count(entry_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic dv, input logic [3:0] d,
                                input logic clr, input logic ent, input logic chg, input logic en,
                                input logic [2:0] cnt, input logic full, input logic cmp,
                                input string name);
        vec_t v;
        v.rst = rst; v.dv = dv; v.d = d; v.clr = clr; v.ent = ent; v.chg = chg; v.en = en;
        v.cnt = cnt; v.full = full; v.cmp = cmp; v.name = name;
        return v;
    endfunction

    function automatic vec_t dig(input logic [3:0] d, input logic [2:0] cnt,
                                 input logic full, input logic cmp, input string name);
        return mk(0, 1, d, 0, 0, 0, 0, cnt, full, cmp, name);
    endfunction

    function automatic vec_t idle(input logic [2:0] cnt, input logic full, input logic cmp,
                                  input string name);
        return mk(0, 0, 4'h0, 0, 0, 0, 0, cnt, full, cmp, name);
    endfunction

    // Drives one cycle of inputs, lets the rising edge take them, then samples 1 time unit later.
    task automatic applyStimulus(input vec_t v);
        reset       = v.rst;
        digit_valid = v.dv;
        digit_in    = v.d;
        clear       = v.clr;
        enter       = v.ent;
        change      = v.chg;
        enable      = v.en;
        @(posedge clock);
        #1;
        reset       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 4'h0;
        clear       = 1'b0;
        enter       = 1'b0;
        change      = 1'b0;
        enable      = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] cnt,
                               input logic full, input logic cmp);
        assertions++;
        if (entry_count !== cnt) begin
            failures++;
            $display("[TB] FAIL %s entry_count: got %0d expected %0d", name, entry_count, cnt);
        end
        assertions++;
        if (entry_full !== full) begin
            failures++;
            $display("[TB] FAIL %s entry_full: got %b expected %b", name, entry_full, full);
        end
        assertions++;
        if (Compare !== cmp) begin
            failures++;
            $display("[TB] FAIL %s Compare: got %b expected %b", name, Compare, cmp);
        end
    endtask

    initial begin
        reset = 1'b1; digit_valid = 1'b0; digit_in = 4'h0;
        clear = 1'b0; enter = 1'b0; change = 1'b0; enable = 1'b0;

        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 3'd0, 0, 0, "reset"));
        // Default code entry, Compare held, then consumed by enter.
        vecs.push_back(dig(4'h1, 3'd1, 0, 0, "t1_d1"));
        vecs.push_back(dig(4'h2, 3'd2, 0, 0, "t1_d2"));
        vecs.push_back(dig(4'h3, 3'd3, 0, 0, "t1_d3"));
        vecs.push_back(dig(4'h4, 3'd4, 1, 1, "t1_d4"));
        vecs.push_back(idle(3'd4, 1, 1, "t1_hold1"));
        vecs.push_back(idle(3'd4, 1, 1, "t1_hold2"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 3'd0, 0, 0, "t1_enter"));
        // Wrong code, and a fifth digit is dropped.
        vecs.push_back(dig(4'h1, 3'd1, 0, 0, "t2_d1"));
        vecs.push_back(dig(4'h2, 3'd2, 0, 0, "t2_d2"));
        vecs.push_back(dig(4'h3, 3'd3, 0, 0, "t2_d3"));
        vecs.push_back(dig(4'h5, 3'd4, 1, 0, "t2_d5"));
        vecs.push_back(dig(4'h4, 3'd4, 1, 0, "t2_drop"));
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 3'd0, 0, 0, "t2_clear"));
        // Enable with a partial entry must not load; held enable on an empty buffer neither.
        vecs.push_back(dig(4'h1, 3'd1, 0, 0, "t4_d1"));
        vecs.push_back(dig(4'h2, 3'd2, 0, 0, "t4_d2"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 3'd2, 0, 0, "t4_en_partial"));
        vecs.push_back(dig(4'h3, 3'd3, 0, 0, "t4_d3"));
        vecs.push_back(dig(4'h4, 3'd4, 1, 1, "t4_d4_still_1234"));
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 3'd0, 0, 0, "t4_clear"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 3'd0, 0, 0, "t4_en_empty1"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 3'd0, 0, 0, "t4_en_empty2"));
        vecs.push_back(dig(4'h5, 3'd1, 0, 0, "t4_d5"));
        vecs.push_back(mk(0, 1, 4'h7, 1, 0, 0, 0, 3'd0, 0, 0, "t4_digit_clear"));
        vecs.push_back(mk(0, 1, 4'h7, 0, 1, 0, 0, 3'd0, 0, 0, "t4_digit_enter"));
        vecs.push_back(dig(4'h1, 3'd1, 0, 0, "t4_chk_d1"));
        vecs.push_back(dig(4'h2, 3'd2, 0, 0, "t4_chk_d2"));
        vecs.push_back(dig(4'h3, 3'd3, 0, 0, "t4_chk_d3"));
        vecs.push_back(dig(4'h4, 3'd4, 1, 1, "t4_chk_d4"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 3'd0, 0, 0, "t4_enter"));
        // Change code to 9876 and confirm old code no longer matches.
        vecs.push_back(dig(4'h9, 3'd1, 0, 0, "t3_d9"));
        vecs.push_back(dig(4'h8, 3'd2, 0, 0, "t3_d8"));
        vecs.push_back(dig(4'h7, 3'd3, 0, 0, "t3_d7"));
        vecs.push_back(dig(4'h6, 3'd4, 1, 0, "t3_d6_old_code"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1, 3'd0, 0, 0, "t3_change_load"));
        vecs.push_back(dig(4'h9, 3'd1, 0, 0, "t3_n9"));
        vecs.push_back(dig(4'h8, 3'd2, 0, 0, "t3_n8"));
        vecs.push_back(dig(4'h7, 3'd3, 0, 0, "t3_n7"));
        vecs.push_back(dig(4'h6, 3'd4, 1, 1, "t3_n6_match"));
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 3'd0, 0, 0, "t3_enter"));
        vecs.push_back(dig(4'h1, 3'd1, 0, 0, "t3_o1"));
        vecs.push_back(dig(4'h2, 3'd2, 0, 0, "t3_o2"));
        vecs.push_back(dig(4'h3, 3'd3, 0, 0, "t3_o3"));
        vecs.push_back(dig(4'h4, 3'd4, 1, 0, "t3_o4_nomatch"));
        vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 3'd0, 0, 0, "t3_clear"));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].cnt, vecs[i].full, vecs[i].cmp);
        end

        // Reset mid-entry after loading 9876 restores the default code.
        applyStimulus(dig(4'h9, 3'd1, 0, 0, "t5_d9"));
        applyStimulus(dig(4'h8, 3'd2, 0, 0, "t5_d8"));
        checkOutput("t5_two_held", 3'd2, 0, 0);
        applyStimulus(mk(1, 1, 4'h7, 0, 0, 0, 0, 3'd0, 0, 0, "t5_reset"));
        checkOutput("t5_after_reset", 3'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(dig(4'(k + 1), 3'(k + 1), 0, 0, "t5_dig"));
        end
        checkOutput("t5_default_restored", 3'd4, 1, 1);
        applyStimulus(mk(0, 0, 4'h0, 0, 0, 1, 0, 3'd0, 0, 0, "t5_change"));
        checkOutput("t5_change_consume", 3'd0, 0, 0);
        applyStimulus(dig(4'h9, 3'd1, 0, 0, "t5_n9"));
        applyStimulus(dig(4'h8, 3'd2, 0, 0, "t5_n8"));
        applyStimulus(dig(4'h7, 3'd3, 0, 0, "t5_n7"));
        applyStimulus(dig(4'h6, 3'd4, 1, 0, "t5_n6"));
        checkOutput("t5_9876_rejected", 3'd4, 1, 0);
        applyStimulus(mk(0, 0, 4'h0, 1, 0, 0, 0, 3'd0, 0, 0, "t5_clear"));
        checkOutput("t5_clear", 3'd0, 0, 0);

`ifdef LOCK_ENTRY_TIMEOUT_EN
        // Partial entry times out after eight idle edges; a full entry never does.
        applyStimulus(dig(4'h1, 3'd1, 0, 0, "to_d1"));
        applyStimulus(dig(4'h2, 3'd2, 0, 0, "to_d2"));
        for (int k = 0; k < 7; k++) applyStimulus(idle(3'd2, 0, 0, "to_idle"));
        checkOutput("to_before_expiry", 3'd2, 0, 0);
        applyStimulus(idle(3'd0, 0, 0, "to_idle8"));
        checkOutput("to_expired", 3'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(dig(4'(k + 1), 3'(k + 1), 0, 0, "to_dig"));
        end
        for (int k = 0; k < 20; k++) applyStimulus(idle(3'd4, 1, 1, "to_full_idle"));
        checkOutput("to_full_persists", 3'd4, 1, 1);
`else
        // Without the timeout a partial entry persists.
        applyStimulus(dig(4'h1, 3'd1, 0, 0, "nt_d1"));
        applyStimulus(dig(4'h2, 3'd2, 0, 0, "nt_d2"));
        for (int k = 0; k < 20; k++) applyStimulus(idle(3'd2, 0, 0, "nt_idle"));
        checkOutput("nt_partial_persists", 3'd2, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/lock_code_store.md
# lock_code_store

Code storage and comparison engine for the combination lock; the responder to the lock-control FSM. It collects keypad digits into an entry buffer and holds the current lock code. It drives the registered `Compare` flag the FSM samples on `enter`/`change`, and it loads a new code when the FSM raises `enable` from its change-code state.

## Interface
- `DIGIT_W`, default 4: bits per keypad digit.
- `NUM_DIGITS`, default 4: digits per code; `CODE_W = DIGIT_W*NUM_DIGITS`.
- `DEFAULT_CODE`, default 16'h1234: stored code after reset.
- `TIMEOUT_CYCLES`, default 1000: idle cycles before entry auto-clear; used only with `LOCK_ENTRY_TIMEOUT_EN`.

- `clock` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `digit_in` input DIGIT_W: keypad digit value.
- `digit_valid` input 1: one-cycle strobe; `digit_in` is valid.
- `clear` input 1: discard the partial entry.
- `enter` input 1: open-attempt key, shared with the FSM.
- `change` input 1: change-code key, shared with the FSM.
- `enable` input 1: from the FSM; commit the entry buffer as the new stored code.
- `Compare` output 1: registered; entry is complete and equals the stored code.
- `entry_full` output 1: registered; NUM_DIGITS digits are held.
- `entry_count` output $clog2(NUM_DIGITS+1): digits currently held.

## Operation
- Registers: `entry_buf[CODE_W]`, `stored_code[CODE_W]`, `entry_count`, `Compare`.
- Digit shift: `entry_buf <= {entry_buf[CODE_W-DIGIT_W-1:0], digit_in}`. The first digit entered ends in the most significant slot.
- `entry_count` increments on an accepted digit.
- Digits arriving with `entry_count == NUM_DIGITS` are dropped; no wrap, no overwrite.
- `entry_full = (entry_count == NUM_DIGITS)`.
- `Compare <= next_full && (next_entry_buf == stored_code_next)`. The comparison uses post-update values, so `Compare` is valid the cycle after the last digit.
- Code load: when `enable && entry_full`, then `stored_code <= entry_buf`. When `enable` is asserted and the entry is not full, the load is ignored and `stored_code` is unchanged.
- Consume: when `enter || change`, clear the entry (`entry_count <= 0`, `entry_buf <= 0`, `Compare <= 0`). The FSM samples the pre-clear `Compare` on the same edge.
- Priority within one cycle:
  - `reset` beats all.
  - Load is evaluated on the pre-clear `entry_buf`.
  - Clear sources (`clear`, `enter`, `change`) beat `digit_valid`; the digit is dropped.
  - A digit accepted alongside `enable` is not loaded.
- Reset values:
  - `stored_code = DEFAULT_CODE`.
  - `entry_buf = 0`.
  - `entry_count = 0`.
  - `entry_full = 0`.
  - `Compare = 0`.
- Reset mid-entry discards the partial entry. Reset mid-change restores `DEFAULT_CODE`.

## Timing
- Digit to `entry_count` update: 1 cycle.
- Last digit to `Compare`/`entry_full` high: 1 cycle, i.e. visible on the edge after the strobe.
- `Compare` stays stable until the next clear/consume/reset edge. It goes low 1 cycle after that edge.
- `enable` to new `stored_code`: 1 cycle. `Compare` reflects the new code for subsequent entries only.
- `enable` must be sampled as a level on the edge. Held `enable` with an empty buffer causes no load.
- No combinational path from any input to any output.

## Configuration
- `LOCK_ENTRY_TIMEOUT_EN` defined: an idle counter resets on every accepted digit. The counter runs only while `0 < entry_count < NUM_DIGITS`. On reaching `TIMEOUT_CYCLES-1`, the entry is cleared on the next edge, exactly as `clear`.
- Not defined: no counter, and `TIMEOUT_CYCLES` is unused. A partial entry persists indefinitely.

## Test plan
- Reset, then digits 1,2,3,4: `entry_count` 1,2,3,4; `Compare=1` and `entry_full=1` one cycle after the 4th strobe. Then `enter`: `Compare=0` next cycle, `entry_count=0`.
- Digits 1,2,3,5: `entry_full=1`, `Compare=0`. A 5th digit 4 is dropped, with `entry_count` staying at 4.
- Digits 9,8,7,6 then `change` together with `enable`: `stored_code=16'h9876`. Then 9,8,7,6: `Compare=1`. Then 1,2,3,4: `Compare=0`.
- `enable` with 2 digits held: `stored_code` stays 16'h1234. `digit_valid` together with `clear`: `entry_count=0`.
- After loading 16'h9876, assert `reset` mid-entry (2 digits held): `stored_code=16'h1234`, `entry_count=0`, `Compare=0`.
- With `LOCK_ENTRY_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`: digits 1,2, then idle 8 cycles gives `entry_count=0`. Digits 1,2,3,4 then idle 20 cycles keeps `Compare=1`.
